task_pulse_responder: RTL and testbench

Single-clock task executor for the far-domain end of the task flag/busy/done handshake: it accepts a one-cycle start flag, generates a programmed train of pulses, and reports completion with a one-cycle done pulse. The block sits in the destination clock domain. START is driven by the crossing's output flag, and TASK_DONE is returned to the crossing's done input. Configuration is latched at start, so the crossing's source side may change it while the task runs.

---
 rtl/task_pulse_responder.sv | 179 +++++++++++++++++
 tb/tb_task_pulse_responder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/task_pulse_responder.sv
// task_pulse_responder
// Far-domain task executor: accepts a one-cycle start flag, emits a train of
// REPEAT pulses (DELAY low cycles then WIDTH high cycles each), then reports
// completion with a one-cycle done pulse. Configuration is captured at start.
//
// state   | meaning
// --------+----------------------------------------------
// ST_IDLE | waiting for i_start
// ST_LOW  | delay phase, o_pulse_out low
// ST_HIGH | pulse phase, o_pulse_out high
// ST_DONE | single completion cycle, o_task_done high
module task_pulse_responder #(
    parameter int CNT_WIDTH = 16,
    parameter int REP_WIDTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic [CNT_WIDTH-1:0] i_delay,
    input  logic [CNT_WIDTH-1:0] i_width,
    input  logic [REP_WIDTH-1:0] i_repeat,
    input  logic                 i_abort,
    output logic                 o_pulse_out,
    output logic                 o_busy,
    output logic                 o_task_done,
    output logic                 o_aborted,
    output logic [REP_WIDTH-1:0] o_pulse_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [REP_WIDTH-1:0] REP_ZERO = '0;
    localparam logic [REP_WIDTH-1:0] REP_ONE  = REP_WIDTH'(1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_WIDTH-1:0] r_delay;
    logic [CNT_WIDTH-1:0] w_delay_nxt;
    logic [CNT_WIDTH-1:0] r_width;
    logic [CNT_WIDTH-1:0] w_width_nxt;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] w_cnt_nxt;
    logic [REP_WIDTH-1:0] r_rep_left;
    logic [REP_WIDTH-1:0] w_rep_left_nxt;
    logic [REP_WIDTH-1:0] r_pulse_cnt;
    logic [REP_WIDTH-1:0] w_pulse_cnt_nxt;
    logic                 w_aborted_nxt;
    logic                 r_pulse_out;
    logic                 r_busy;
    logic                 r_task_done;
    logic                 r_aborted;

    // Next-state and datapath decode. r_cnt is a down-counter holding the
    // cycles left in the current phase minus one, so a phase ends when it
    // reads zero; this keeps the maximum DELAY/WIDTH values representable.
    always_comb begin
        w_state_nxt     = r_state;
        w_delay_nxt     = r_delay;
        w_width_nxt     = r_width;
        w_cnt_nxt       = r_cnt;
        w_rep_left_nxt  = r_rep_left;
        w_pulse_cnt_nxt = r_pulse_cnt;
        w_aborted_nxt   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // ABORT is deliberately not looked at here: a start that
                // coincides with an abort is still accepted.
                if (i_start) begin
                    w_delay_nxt     = i_delay;
                    w_width_nxt     = i_width;
                    w_rep_left_nxt  = i_repeat;
                    w_pulse_cnt_nxt = REP_ZERO;
                    if ((i_width == CNT_ZERO) || (i_repeat == REP_ZERO)) begin
                        w_state_nxt = ST_DONE;
                    end else if (i_delay == CNT_ZERO) begin
                        w_state_nxt = ST_HIGH;
                        w_cnt_nxt   = i_width - CNT_ONE;
                    end else begin
                        w_state_nxt = ST_LOW;
                        w_cnt_nxt   = i_delay - CNT_ONE;
                    end
                end
            end

            ST_LOW: begin
                if (i_abort) begin
                    w_state_nxt   = ST_DONE;
                    w_aborted_nxt = 1'b1;
                end else if (r_cnt == CNT_ZERO) begin
                    w_state_nxt = ST_HIGH;
                    w_cnt_nxt   = r_width - CNT_ONE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end

            ST_HIGH: begin
                // Abort takes priority over pulse completion, so a pulse cut
                // on its last high cycle is not counted.
                if (i_abort) begin
                    w_state_nxt   = ST_DONE;
                    w_aborted_nxt = 1'b1;
                end else if (r_cnt == CNT_ZERO) begin
                    w_pulse_cnt_nxt = r_pulse_cnt + REP_ONE;
                    w_rep_left_nxt  = r_rep_left - REP_ONE;
                    if (r_rep_left == REP_ONE) begin
                        w_state_nxt = ST_DONE;
                    end else if (r_delay == CNT_ZERO) begin
                        w_state_nxt = ST_HIGH;
                        w_cnt_nxt   = r_width - CNT_ONE;
                    end else begin
                        w_state_nxt = ST_LOW;
                        w_cnt_nxt   = r_delay - CNT_ONE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end

            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, latched configuration and counters.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_delay     <= '0;
            r_width     <= '0;
            r_cnt       <= '0;
            r_rep_left  <= '0;
            r_pulse_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_delay     <= w_delay_nxt;
            r_width     <= w_width_nxt;
            r_cnt       <= w_cnt_nxt;
            r_rep_left  <= w_rep_left_nxt;
            r_pulse_cnt <= w_pulse_cnt_nxt;
        end
    end

    // Outputs are flopped from the next-state decode so they change on the
    // same edge as the state and have no path back to the inputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pulse_out <= 1'b0;
            r_busy      <= 1'b0;
            r_task_done <= 1'b0;
            r_aborted   <= 1'b0;
        end else begin
            r_pulse_out <= (w_state_nxt == ST_HIGH);
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_task_done <= (w_state_nxt == ST_DONE);
            r_aborted   <= w_aborted_nxt;
        end
    end

    assign o_pulse_out = r_pulse_out;
    assign o_busy      = r_busy;
    assign o_task_done = r_task_done;
    assign o_aborted   = r_aborted;
    assign o_pulse_cnt = r_pulse_cnt;

endmodule

// File: tb/tb_task_pulse_responder.sv
// Bench for task_pulse_responder: a timeline model (outputs computed from the
// edge offset since start) checked every cycle, plus directed tasks with
// hand-computed expectations and a randomized traffic phase.
module tb_task_pulse_responder;

    logic        clk;
    logic        rst_n;
    logic        i_start;
    logic [15:0] i_delay;
    logic [15:0] i_width;
    logic [7:0]  i_repeat;
    logic        i_abort;
    logic        o_pulse_out;
    logic        o_busy;
    logic        o_task_done;
    logic        o_aborted;
    logic [7:0]  o_pulse_cnt;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 0;

    task_pulse_responder #(.CNT_WIDTH(16), .REP_WIDTH(8)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (i_start),
        .i_delay     (i_delay),
        .i_width     (i_width),
        .i_repeat    (i_repeat),
        .i_abort     (i_abort),
        .o_pulse_out (o_pulse_out),
        .o_busy      (o_busy),
        .o_task_done (o_task_done),
        .o_aborted   (o_aborted),
        .o_pulse_cnt (o_pulse_cnt)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural timeline model ----------------
    int m_act = 0, m_t = 0, m_D = 0, m_W = 0, m_R = 0, m_P = 1, m_T = 0;
    int m_degen = 0, m_ended = 0;
    int e_pulse = 0, e_busy = 0, e_done = 0, e_ab = 0, e_cnt = 0;

    // Expected outputs t edges after the start edge of a normal task.
    task automatic eval_at(input int t);
        e_busy = 1;
        e_ab   = 0;
        if (t < m_T) begin
            e_pulse = ((t % m_P) >= m_D) ? 1 : 0;
            e_cnt   = t / m_P;
            e_done  = 0;
        end else begin
            e_pulse = 0;
            e_cnt   = m_R;
            e_done  = 1;
        end
    endtask

    // Model advance on every edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_act = 0; e_pulse = 0; e_busy = 0; e_done = 0; e_ab = 0; e_cnt = 0;
        end else if (m_act != 0) begin
            m_t++;
            if (m_ended != 0 || m_t > m_T) begin
                m_act = 0; e_pulse = 0; e_busy = 0; e_done = 0; e_ab = 0;
            end else if (i_abort && m_degen == 0) begin
                m_ended = 1;
                e_pulse = 0; e_busy = 1; e_done = 1; e_ab = 1;
                e_cnt   = (m_t - 1) / m_P;
            end else begin
                eval_at(m_t);
            end
        end else if (i_start) begin
            m_act   = 1;
            m_t     = 0;
            m_D     = int'(i_delay);
            m_W     = int'(i_width);
            m_R     = int'(i_repeat);
            m_P     = m_D + m_W;
            m_degen = (m_W == 0 || m_R == 0) ? 1 : 0;
            m_ended = 0;
            if (m_degen != 0) begin
                m_T = 0; m_ended = 1;
                e_pulse = 0; e_busy = 1; e_done = 1; e_ab = 0; e_cnt = 0;
            end else begin
                m_T = m_R * m_P;
                eval_at(0);
            end
        end
    end

    // Compare process: every cycle out of reset.
    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            chk("mdl_pulse_out", int'(o_pulse_out), e_pulse);
            chk("mdl_busy",      int'(o_busy),      e_busy);
            chk("mdl_task_done", int'(o_task_done), e_done);
            chk("mdl_aborted",   int'(o_aborted),   e_ab);
            chk("mdl_pulse_cnt", int'(o_pulse_cnt), e_cnt);
        end
    end

    // ---------------- directed task with literal expectations ----------------
    // abort_at: -1 none, 0 together with start, n>0 sampled n edges after start.
    // start2_at: n>0 issues a second start n edges after the first.
    task automatic run_task(input string nm, input int d, input int w, input int r,
                            input int abort_at, input int start2_at,
                            input int exp_done_t, input int exp_hi, input int exp_rises,
                            input int exp_cnt, input int exp_ab);
        int hi = 0, rises = 0, done_t = -1, ndone = 0, cnt_at = -1, ab_at = -1;
        logic prev = 0;
        i_delay  = 16'(d);
        i_width  = 16'(w);
        i_repeat = 8'(r);
        i_start  = 1;
        i_abort  = (abort_at == 0);
        @(posedge clk); #1;
        i_start  = 0;
        i_abort  = 0;
        // change config mid-task: the block must keep the latched copy
        i_delay  = 16'($urandom_range(0, 7));
        i_width  = 16'($urandom_range(0, 7));
        i_repeat = 8'($urandom_range(0, 7));
        for (int t = 0; t < 1000; t++) begin
            i_abort = (abort_at > 0 && t == abort_at - 1);
            i_start = (start2_at > 0 && t == start2_at - 1);
            @(negedge clk);
            if (o_pulse_out) begin
                hi++;
                if (!prev) rises++;
            end
            prev = o_pulse_out;
            if (o_task_done) begin
                ndone++;
                if (done_t < 0) begin
                    done_t = t;
                    cnt_at = int'(o_pulse_cnt);
                    ab_at  = int'(o_aborted);
                end
            end
            if (done_t >= 0 && t == done_t + 1) chk({nm, "_busy_after"}, int'(o_busy), 0);
            @(posedge clk); #1;
            if (done_t >= 0 && t >= done_t + 2) break;
        end
        i_abort = 0;
        i_start = 0;
        chk({nm, "_done_edge"}, done_t, exp_done_t);
        chk({nm, "_high_cycles"}, hi, exp_hi);
        chk({nm, "_rises"}, rises, exp_rises);
        chk({nm, "_done_count"}, ndone, 1);
        chk({nm, "_pulse_cnt"}, cnt_at, exp_cnt);
        chk({nm, "_aborted"}, ab_at, exp_ab);
    endtask

    initial begin
        rst_n    = 0;
        i_start  = 0;
        i_abort  = 0;
        i_delay  = 0;
        i_width  = 0;
        i_repeat = 0;
        #1;
        chk("rst_pulse_out", int'(o_pulse_out), 0);
        chk("rst_busy",      int'(o_busy),      0);
        chk("rst_task_done", int'(o_task_done), 0);
        chk("rst_aborted",   int'(o_aborted),   0);
        chk("rst_pulse_cnt", int'(o_pulse_cnt), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        chk_en = 1;
        repeat (2) @(posedge clk);
        #1;

        //        name        D  W  R    ab  st2 done hi  rise cnt ab
        run_task("basic",     3, 2, 1,   -1, -1,   5,  2,  1,  1, 0);
        run_task("repeat",    1, 1, 4,   -1, -1,   8,  4,  4,  4, 0);
        run_task("merged",    0, 5, 2,   -1, -1,  10, 10,  1,  2, 0);
        run_task("degen_w0",  2, 0, 3,   -1, -1,   0,  0,  0,  0, 0);
        run_task("degen_r0",  2, 3, 0,   -1, -1,   0,  0,  0,  0, 0);
        run_task("abort",     2, 4, 3,    9, -1,   9,  5,  2,  1, 1);
        run_task("abort_last",1, 2, 2,    6, -1,   6,  4,  2,  1, 1);
        run_task("start_abrt",1, 1, 1,    0, -1,   2,  1,  1,  1, 0);
        run_task("busy_start",2, 4, 2,   -1,  5,  12,  8,  2,  2, 0);
        run_task("rep_max",   0, 1, 255, -1, -1, 255,255,  1,255, 0);

        // reset in the middle of a task
        i_delay = 2; i_width = 4; i_repeat = 2; i_start = 1;
        @(posedge clk); #1;
        i_start = 0;
        repeat (6) @(posedge clk);
        rst_n = 0;
        #1;
        chk("midrst_pulse_out", int'(o_pulse_out), 0);
        chk("midrst_busy",      int'(o_busy),      0);
        chk("midrst_task_done", int'(o_task_done), 0);
        chk("midrst_aborted",   int'(o_aborted),   0);
        chk("midrst_pulse_cnt", int'(o_pulse_cnt), 0);
        repeat (3) begin
            @(negedge clk);
            chk("midrst_no_done", int'(o_task_done), 0);
        end
        @(posedge clk); #1 rst_n = 1;
        repeat (2) @(posedge clk);
        #1;

        // randomized traffic, configuration churning every cycle
        for (int c = 0; c < 4000; c++) begin
            i_start  = ($urandom_range(0, 5) == 0);
            i_abort  = ($urandom_range(0, 24) == 0);
            i_delay  = 16'($urandom_range(0, 4));
            i_width  = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 4));
            i_repeat = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 4));
            if ($urandom_range(0, 599) == 0) rst_n = 0;
            else rst_n = 1;
            @(posedge clk); #1;
        end
        rst_n   = 1;
        i_start = 0;
        i_abort = 0;
        repeat (3) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
